// File: rtl/addr_reg_file_n.sv
// addr_reg_file_n: parametrised address register file (PC/AR/SP successor).
// NUM_REGS registers share one write bus and one function select; each
// register is enabled by its own active-low RegSel bit. Increment and
// decrement keep a sticky per-register wrap flag. Two read ports index the
// file and are either combinational or registered (OUT_REG).
module addr_reg_file_n #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2,
  parameter int STEP     = 1,
  parameter int OUT_REG  = 0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [WIDTH-1:0]    I,
  input  logic [2:0]          FunSel,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [SEL_W-1:0]    OutCSel,
  input  logic [SEL_W-1:0]    OutDSel,
  output logic [WIDTH-1:0]    OutC,
  output logic [WIDTH-1:0]    OutD,
  output logic [NUM_REGS-1:0] WrapFlag
);

  localparam int H         = WIDTH / 2;
  localparam int NUM_SLOTS = 2 ** SEL_W;

  // Step as a WIDTH-bit value; its complement is the largest value that can
  // still be incremented without wrapping (2**WIDTH-1-STEP).
  localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] INC_LIMIT = ~STEP_V;

  logic [WIDTH-1:0]    regQ    [NUM_REGS];
  logic [WIDTH-1:0]    nextQ   [NUM_REGS];
  logic [NUM_REGS-1:0] wrapQ;
  logic [NUM_REGS-1:0] nextWrap;
  logic [WIDTH-1:0]    regPad  [NUM_SLOTS];
  logic [WIDTH-1:0]    selC;
  logic [WIDTH-1:0]    selD;

  // Next value and next wrap flag of every register from its own prior state.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      nextQ[k]    = regQ[k];
      nextWrap[k] = wrapQ[k];
      if (!RegSel[k]) begin
        case (FunSel)
          3'b000: begin
            nextQ[k]    = regQ[k] - STEP_V;
            nextWrap[k] = wrapQ[k] | (regQ[k] < STEP_V);
          end
          3'b001: begin
            nextQ[k]    = regQ[k] + STEP_V;
            nextWrap[k] = wrapQ[k] | (regQ[k] > INC_LIMIT);
          end
          3'b010: begin
            nextQ[k]    = I;
            nextWrap[k] = 1'b0;
          end
          3'b011: begin
            nextQ[k]    = '0;
            nextWrap[k] = 1'b0;
          end
          3'b100: begin
            nextQ[k]    = {{(WIDTH - H){1'b0}}, I[H-1:0]};
            nextWrap[k] = 1'b0;
          end
          3'b101: begin
            nextQ[k]    = {regQ[k][WIDTH-1:H], I[H-1:0]};
            nextWrap[k] = 1'b0;
          end
          3'b110: begin
            nextQ[k]    = {I[H-1:0], regQ[k][H-1:0]};
            nextWrap[k] = 1'b0;
          end
          3'b111: begin
            nextQ[k]    = {{(WIDTH - H){I[H-1]}}, I[H-1:0]};
            nextWrap[k] = 1'b0;
          end
          default: begin
            nextQ[k]    = regQ[k];
            nextWrap[k] = wrapQ[k];
          end
        endcase
      end else begin
        nextQ[k]    = regQ[k];
        nextWrap[k] = wrapQ[k];
      end
    end
  end

  // Register file and wrap flags; reset wins over any pending operation.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regQ[k] <= '0;
      end
      wrapQ <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regQ[k] <= nextQ[k];
      end
      wrapQ <= nextWrap;
    end
  end

  // Zero-padded view of the file so every select code maps to a slot;
  // codes beyond NUM_REGS read as zero.
  always_comb begin
    for (int j = 0; j < NUM_SLOTS; j++) begin
      regPad[j] = '0;
    end
    for (int k = 0; k < NUM_REGS; k++) begin
      regPad[k] = regQ[k];
    end
  end

  assign selC     = regPad[OutCSel];
  assign selD     = regPad[OutDSel];
  assign WrapFlag = wrapQ;

  if (OUT_REG != 0) begin : gRegOut
    logic [WIDTH-1:0] outCReg;
    logic [WIDTH-1:0] outDReg;

    // Registered read ports sample the pre-edge selection every cycle.
    always_ff @(posedge Clock) begin
      if (Reset) begin
        outCReg <= '0;
        outDReg <= '0;
      end else begin
        outCReg <= selC;
        outDReg <= selD;
      end
    end

    assign OutC = outCReg;
    assign OutD = outDReg;
  end else begin : gCombOut
    assign OutC = selC;
    assign OutD = selD;
  end

endmodule

// File: tb/tb_addr_reg_file_n.sv
// Directed bench for addr_reg_file_n: a default instance (STEP=1,
// combinational reads), a STEP=4 registered-read instance and a 3-register
// instance with an out-of-range select.
module tb_addr_reg_file_n;

  logic        Clock;
  logic        Reset;
  logic [15:0] I;
  logic [2:0]  FunSel;
  logic [3:0]  regSelA, regSelB;
  logic [2:0]  regSelC;
  logic [1:0]  cSelA, dSelA, cSelB, dSelB, cSelC, dSelC;
  logic [15:0] outCA, outDA, outCB, outDB, outCC, outDC;
  logic [3:0]  wrapA, wrapB;
  logic [2:0]  wrapC;

  int testCnt = 0;
  int failCnt = 0;

  typedef struct {
    logic [2:0]  fs;
    logic [3:0]  rs;
    logic [15:0] i;
    logic [1:0]  cs;
    logic [1:0]  ds;
    logic [15:0] expC;
    logic [15:0] expD;
    logic [3:0]  expW;
  } vec_t;

  vec_t vecs[21];

  addr_reg_file_n #(.WIDTH(16), .NUM_REGS(4), .SEL_W(2), .STEP(1), .OUT_REG(0)) dutA (
    .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(regSelA),
    .OutCSel(cSelA), .OutDSel(dSelA), .OutC(outCA), .OutD(outDA), .WrapFlag(wrapA)
  );

  addr_reg_file_n #(.WIDTH(16), .NUM_REGS(4), .SEL_W(2), .STEP(4), .OUT_REG(1)) dutB (
    .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(regSelB),
    .OutCSel(cSelB), .OutDSel(dSelB), .OutC(outCB), .OutD(outDB), .WrapFlag(wrapB)
  );

  addr_reg_file_n #(.WIDTH(16), .NUM_REGS(3), .SEL_W(2), .STEP(1), .OUT_REG(0)) dutC (
    .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(regSelC),
    .OutCSel(cSelC), .OutDSel(dSelC), .OutC(outCC), .OutD(outDC), .WrapFlag(wrapC)
  );

  // Free-running clock, 10 time-unit period.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", testCnt);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    testCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idleAll();
    regSelA = 4'b1111;
    regSelB = 4'b1111;
    regSelC = 3'b111;
  endtask

  initial begin
    vecs[0]  = '{3'b010, 4'b1101, 16'hFFFE, 2'd1, 2'd0, 16'hFFFE, 16'h0000, 4'b0000};
    vecs[1]  = '{3'b001, 4'b1101, 16'h0000, 2'd1, 2'd1, 16'hFFFF, 16'hFFFF, 4'b0000};
    vecs[2]  = '{3'b001, 4'b1101, 16'h0000, 2'd1, 2'd1, 16'h0000, 16'h0000, 4'b0010};
    vecs[3]  = '{3'b010, 4'b1101, 16'h1234, 2'd1, 2'd0, 16'h1234, 16'h0000, 4'b0000};
    vecs[4]  = '{3'b010, 4'b1110, 16'hABCD, 2'd0, 2'd1, 16'hABCD, 16'h1234, 4'b0000};
    vecs[5]  = '{3'b101, 4'b1110, 16'h0012, 2'd0, 2'd0, 16'hAB12, 16'hAB12, 4'b0000};
    vecs[6]  = '{3'b110, 4'b1110, 16'h0034, 2'd0, 2'd0, 16'h3412, 16'h3412, 4'b0000};
    vecs[7]  = '{3'b111, 4'b1110, 16'h0080, 2'd0, 2'd0, 16'hFF80, 16'hFF80, 4'b0000};
    vecs[8]  = '{3'b100, 4'b1110, 16'h1280, 2'd0, 2'd0, 16'h0080, 16'h0080, 4'b0000};
    vecs[9]  = '{3'b000, 4'b1110, 16'h0000, 2'd0, 2'd1, 16'h007F, 16'h1234, 4'b0000};
    vecs[10] = '{3'b011, 4'b1110, 16'h0000, 2'd0, 2'd0, 16'h0000, 16'h0000, 4'b0000};
    vecs[11] = '{3'b000, 4'b1110, 16'h0000, 2'd0, 2'd2, 16'hFFFF, 16'h0000, 4'b0001};
    vecs[12] = '{3'b011, 4'b1111, 16'h0000, 2'd0, 2'd0, 16'hFFFF, 16'hFFFF, 4'b0001};
    vecs[13] = '{3'b111, 4'b1110, 16'h007F, 2'd0, 2'd0, 16'h007F, 16'h007F, 4'b0000};
    vecs[14] = '{3'b010, 4'b1011, 16'h2222, 2'd2, 2'd1, 16'h2222, 16'h1234, 4'b0000};
    vecs[15] = '{3'b010, 4'b0111, 16'h3333, 2'd3, 2'd0, 16'h3333, 16'h007F, 4'b0000};
    vecs[16] = '{3'b011, 4'b0000, 16'h0000, 2'd3, 2'd0, 16'h0000, 16'h0000, 4'b0000};
    vecs[17] = '{3'b011, 4'b0000, 16'h0000, 2'd1, 2'd2, 16'h0000, 16'h0000, 4'b0000};
    vecs[18] = '{3'b000, 4'b0000, 16'h0000, 2'd0, 2'd3, 16'hFFFF, 16'hFFFF, 4'b1111};
    vecs[19] = '{3'b010, 4'b1101, 16'h0005, 2'd1, 2'd1, 16'h0005, 16'h0005, 4'b1101};
    vecs[20] = '{3'b001, 4'b0000, 16'h0000, 2'd1, 2'd2, 16'h0006, 16'h0000, 4'b1101};

    Reset  = 1'b1;
    I      = 16'h0000;
    FunSel = 3'b011;
    idleAll();
    cSelA = 2'd0; dSelA = 2'd0;
    cSelB = 2'd0; dSelB = 2'd0;
    cSelC = 2'd0; dSelC = 2'd0;
    tick();
    tick();
    Reset = 1'b0;

    // Preload every register to all-ones via clear then decrement (wrap set).
    FunSel = 3'b011; regSelA = 4'b0000; regSelB = 4'b0000; regSelC = 3'b000;
    tick();
    FunSel = 3'b000;
    cSelA = 2'd2; dSelA = 2'd3; cSelC = 2'd3; dSelC = 2'd2; cSelB = 2'd1; dSelB = 2'd2;
    tick();
    chk("preload_A_C", outCA, 16'hFFFF);
    chk("preload_A_wrap", {12'h000, wrapA}, 16'h000F);
    chk("preload_B_wrap", {12'h000, wrapB}, 16'h000F);
    chk("C_oob_sel", outCC, 16'h0000);
    chk("C_sel2", outDC, 16'hFFFF);

    // Reset overrides an enabled load of all-ones.
    Reset = 1'b1; FunSel = 3'b010; I = 16'hFFFF;
    tick();
    chk("rst_A_C", outCA, 16'h0000);
    chk("rst_A_D", outDA, 16'h0000);
    chk("rst_A_wrap", {12'h000, wrapA}, 16'h0000);
    chk("rst_B_C", outCB, 16'h0000);
    chk("rst_B_D", outDB, 16'h0000);
    chk("rst_B_wrap", {12'h000, wrapB}, 16'h0000);
    chk("rst_C_D", outDC, 16'h0000);
    chk("rst_C_wrap", {13'h0000, wrapC}, 16'h0000);
    Reset = 1'b0;
    idleAll();
    tick();
    chk("rst_B_reg1", outCB, 16'h0000);
    chk("rst_B_reg2", outDB, 16'h0000);

    // Table-driven operations on instance A.
    for (int v = 0; v < 21; v++) begin
      FunSel  = vecs[v].fs;
      regSelA = vecs[v].rs;
      I       = vecs[v].i;
      cSelA   = vecs[v].cs;
      dSelA   = vecs[v].ds;
      tick();
      chk($sformatf("vec%0d_C", v), outCA, vecs[v].expC);
      chk($sformatf("vec%0d_D", v), outDA, vecs[v].expD);
      chk($sformatf("vec%0d_wrap", v), {12'h000, wrapA}, {12'h000, vecs[v].expW});
    end
    idleAll();

    // Combinational port: no write-through before the edge, visible after it.
    FunSel = 3'b010; I = 16'h5A5A; regSelA = 4'b0111; cSelA = 2'd3;
    #1;
    chk("A_no_writethru", outCA, 16'h0000);
    tick();
    chk("A_write_visible", outCA, 16'h5A5A);
    idleAll();

    // Instance B, STEP=4: decrement wraps below zero, flag stays sticky.
    FunSel = 3'b010; I = 16'h0002; regSelB = 4'b1011; cSelB = 2'd2;
    tick();
    chk("B_load_lag", outCB, 16'h0000);
    FunSel = 3'b000;
    tick();
    chk("B_dec1_out", outCB, 16'h0002);
    chk("B_dec1_wrap", {12'h000, wrapB}, 16'h0004);
    tick();
    chk("B_dec2_out", outCB, 16'hFFFE);
    chk("B_dec2_wrap", {12'h000, wrapB}, 16'h0004);
    idleAll();
    tick();
    chk("B_dec2_val", outCB, 16'hFFFA);

    // Instance B registered port: data and select each lag one edge.
    FunSel = 3'b010; I = 16'h1111; regSelB = 4'b0111; cSelB = 2'd3; dSelB = 2'd3;
    tick();
    chk("B_r3_old", outCB, 16'h0000);
    I = 16'h5A5A;
    tick();
    chk("B_r3_edge_n", outCB, 16'h1111);
    idleAll();
    tick();
    chk("B_r3_edge_n1", outCB, 16'h5A5A);
    chk("B_same_sel", outDB, 16'h5A5A);
    cSelB = 2'd2;
    #1;
    chk("B_sel_hold", outCB, 16'h5A5A);
    tick();
    chk("B_sel_lag", outCB, 16'hFFFA);
    chk("B_wrap_hold", {12'h000, wrapB}, 16'h0004);

    // Instance C: decrement from zero wraps register 0 only.
    FunSel = 3'b000; regSelC = 3'b110; cSelC = 2'd0; dSelC = 2'd3;
    tick();
    chk("C_dec_val", outCC, 16'hFFFF);
    chk("C_dec_oob", outDC, 16'h0000);
    chk("C_dec_wrap", {13'h0000, wrapC}, 16'h0001);
    idleAll();

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/addr_reg_file_n.md
Name: addr_reg_file_n

Overview:
Parametrised address register file, the next generation of the fixed 3-register PC/AR/SP address file.
- NUM_REGS registers of WIDTH bits each.
- Shared input bus and per-register active-low enable mask.
- 3-bit function select that adds half-word loads and sign extension.
- Configurable increment/decrement step with sticky per-register wrap flags.
- Two independent read ports, combinational or registered.
- Sits between the ALU/memory data path and the address bus feeding instruction/data memory.

Parameters:
- WIDTH, 16, register and bus width in bits; even, >= 4.
- NUM_REGS, 4, number of registers; 2..16.
- SEL_W, 2, read-select width; must satisfy 2**SEL_W >= NUM_REGS.
- STEP, 1, increment/decrement amount; 1 <= STEP < 2**WIDTH.
- OUT_REG, 0, 0 = combinational read ports; 1 = registered read ports, 1-cycle latency.

Ports:
- Clock  input  1  sole clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- I  input  WIDTH  shared write data.
- FunSel  input  3  operation applied to every enabled register.
- RegSel  input  NUM_REGS  active-low enables; bit k = 0 enables register k.
- OutCSel  input  SEL_W  read-port C index.
- OutDSel  input  SEL_W  read-port D index.
- OutC  output  WIDTH  read-port C data.
- OutD  output  WIDTH  read-port D data.
- WrapFlag  output  NUM_REGS  sticky wrap indicator, bit k for register k.

Behaviour:
- Reset (Reset=1 at a rising edge):
  - All registers clear to 0 and all WrapFlag bits clear to 0.
  - When OUT_REG=1, the OutC/OutD registers clear to 0.
  - Reset overrides FunSel/RegSel in that cycle.
  - Reset asserted mid-sequence discards the pending operation.
- Register k updates at the edge only when RegSel[k]=0 and Reset=0; otherwise it holds.
- FunSel encoding (H = WIDTH/2), applied at the edge:
  - 000: Q <= Q - STEP, modulo 2**WIDTH.
  - 001: Q <= Q + STEP, modulo 2**WIDTH.
  - 010: Q <= I.
  - 011: Q <= 0.
  - 100: Q <= {0, I[H-1:0]}, upper half cleared.
  - 101: Q[H-1:0] <= I[H-1:0], upper half held.
  - 110: Q[WIDTH-1:H] <= I[H-1:0], lower half held.
  - 111: Q <= sign-extend(I[H-1:0]).
- WrapFlag[k], for an enabled register only:
  - Set when 001 and Q > 2**WIDTH-1-STEP, i.e. the result wrapped past max.
  - Set when 000 and Q < STEP, i.e. the result wrapped below 0.
  - Cleared by any of codes 010..111.
  - Unchanged by a non-wrapping 000/001 and by a disabled register.
  - Readable the cycle after the wrapping edge.
- Multiple enable bits low: every enabled register performs the same operation independently. Each register's wrap is judged on its own prior value.
- All RegSel bits high: no state change; WrapFlag holds.
- Read ports:
  - Index >= NUM_REGS drives 0.
  - OutCSel = OutDSel is legal; both ports show the same data.
- OUT_REG=0:
  - OutC/OutD are combinational from the current register contents.
  - A write appears on the outputs only after the edge; no write-through.
- OUT_REG=1:
  - OutC/OutD are registered, sampling the selected register's pre-edge value and the select inputs at each edge.
  - Data therefore lags a register update by one cycle and lags a select change by one cycle.
- No X propagation: every output is defined from the first post-reset cycle.

Test Plan:
- Reset with all registers preloaded to 16'hFFFF -> next cycle all registers, OutC, OutD, WrapFlag = 0; Reset with RegSel=0 and FunSel=010 still yields 0.
- Defaults; load reg1=16'hFFFE (RegSel=4'b1101, FunSel=010); issue 001 twice -> reg1=16'hFFFF with WrapFlag[1]=0, then reg1=16'h0000 with WrapFlag[1]=1; then 010 I=16'h1234 -> reg1=16'h1234, WrapFlag[1]=0.
- STEP=4, reg2=16'h0002, FunSel=000 -> reg2=16'hFFFE, WrapFlag[2]=1; a further 000 -> 16'hFFFA, flag stays 1.
- Half ops on reg0=16'hABCD:
  - 101 I=16'h0012 -> 16'hAB12.
  - 110 I=16'h0034 -> 16'h3412.
  - 111 I=16'h0080 -> 16'hFF80.
  - 100 I=16'h1280 -> 16'h0080.
- RegSel=4'b0000, FunSel=011 after distinct loads -> all four registers 0 in one edge; NUM_REGS=3, OutCSel=2'b11 -> OutC=0.
- OUT_REG=1: reg3 loaded with 16'h5A5A at edge n while OutCSel=3 -> OutC shows old reg3 after edge n and 16'h5A5A after edge n+1; OUT_REG=0 shows 16'h5A5A right after edge n.
